// File: rtl/frame_serializer.sv
// Serialises one frame as: start bit (0), 6 address bits, size payload bits MSB first,
// then GAP idle-high cycles. Outputs are registered and reflect the state being entered.
module frame_serializer #(
    parameter int unsigned GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  port_in,
    input  logic [1:0]  line_in,
    input  logic [5:0]  size_in,
    input  logic [62:0] data_in,
    output logic        serOut,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DATA_W = 63;
    localparam int unsigned ADDR_W = 6;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        ADDR  = 3'd2,
        DATA  = 3'd3,
        GAP_S = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [3:0]          port_q, port_d;
    logic [1:0]          line_q, line_d;
    logic [CNT_W-1:0]    size_q, size_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                serout_q, serout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [ADDR_W-1:0]   addr;
    logic [CNT_W-1:0]    cnt_m1;
    logic [CNT_W-1:0]    size_m1;

    assign addr    = {port_q, line_q};
    assign cnt_m1  = cnt_q - CNT_W'(1);
    assign size_m1 = size_q - CNT_W'(1);

    // Next state plus the output value belonging to that next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        port_d   = port_q;
        line_d   = line_q;
        size_d   = size_q;
        data_d   = data_q;
        serout_d = 1'b1;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (size_in != '0) begin
                        port_d   = port_in;
                        line_d   = line_in;
                        size_d   = size_in;
                        data_d   = data_in;
                        state_d  = START;
                        serout_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d  = ADDR;
                cnt_d    = ADDR_LAST;
                serout_d = addr[ADDR_LAST[2:0]];
            end
            ADDR: begin
                if (cnt_q == '0) begin
                    state_d  = DATA;
                    cnt_d    = size_m1;
                    serout_d = data_q[size_m1];
                end else begin
                    cnt_d    = cnt_m1;
                    serout_d = addr[cnt_m1[2:0]];
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    state_d = GAP_S;
                    cnt_d   = GAP_LAST;
                    done_d  = 1'b1;
                end else begin
                    cnt_d    = cnt_m1;
                    serout_d = data_q[cnt_m1];
                end
            end
            GAP_S: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_m1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            port_q   <= '0;
            line_q   <= '0;
            size_q   <= '0;
            data_q   <= '0;
            serout_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            port_q   <= port_d;
            line_q   <= line_d;
            size_q   <= size_d;
            data_q   <= data_d;
            serout_q <= serout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign serOut = serout_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: a GAP=2 instance and a GAP=1 instance share stimulus.
module tb_frame_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  port_in;
    logic [1:0]  line_in;
    logic [5:0]  size_in;
    logic [62:0] data_in;

    logic ser_a, busy_a, done_a, err_a;
    logic ser_b, busy_b, done_b, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    frame_serializer #(.GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .port_in(port_in), .line_in(line_in),
        .size_in(size_in), .data_in(data_in),
        .serOut(ser_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    frame_serializer #(.GAP(1)) dut_g1 (
        .clk(clk), .rst(rst), .start(start), .port_in(port_in), .line_in(line_in),
        .size_in(size_in), .data_in(data_in),
        .serOut(ser_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records n cycles of one instance; optionally pulses start for one cycle at index pulse_at.
    task automatic capture(input int n, input bit g1, input int pulse_at,
                           output logic [127:0] ser, output int nbusy, output int ndone,
                           output int nerr, output int first_done);
        logic s, b, d, e;
        ser = '0; nbusy = 0; ndone = 0; nerr = 0; first_done = -1;
        for (int i = 0; i < n; i++) begin
            s = g1 ? ser_b  : ser_a;
            b = g1 ? busy_b : busy_a;
            d = g1 ? done_b : done_a;
            e = g1 ? err_b  : err_a;
            ser = {ser[126:0], s};
            if (b) nbusy++;
            if (d) begin
                if (first_done < 0) first_done = i;
                ndone++;
            end
            if (e) nerr++;
            if (pulse_at >= 0) start = (i == pulse_at);
            tick();
        end
    endtask

    task automatic set_frame1();
        port_in = 4'b1001;
        line_in = 2'b11;
        size_in = 6'd5;
        data_in = 63'h0000_0000_0000_0016;
    endtask

    task automatic scramble();
        port_in = 4'b0110;
        line_in = 2'b00;
        size_in = 6'd40;
        data_in = 63'h1234_5678_9ABC_DEF0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0;
        port_in = '0; line_in = '0; size_in = '0; data_in = '0;
        repeat (3) tick();
        total++;
        if ({ser_a, busy_a, done_a, err_a} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_a: ser/busy/done/err=%b expected 1000", {ser_a, busy_a, done_a, err_a});
        end
        total++;
        if ({ser_b, busy_b, done_b, err_b} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_b: ser/busy/done/err=%b expected 1000", {ser_b, busy_b, done_b, err_b});
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [127:0] ser;
        int nb, nd, ne, fd;
        set_frame1();
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        capture(16, 1'b0, -1, ser, nb, nd, ne, fd);
        total++;
        if (ser !== 128'(16'h4F6F)) begin
            bad++;
            $display("FAIL frame_ser: got %h expected 4f6f", ser[15:0]);
        end
        total++;
        if (nb !== 14) begin
            bad++;
            $display("FAIL frame_busy: got %0d expected 14", nb);
        end
        total++;
        if (nd !== 1 || fd !== 12) begin
            bad++;
            $display("FAIL frame_done: count=%0d at=%0d expected 1 at 12", nd, fd);
        end
    endtask

    task automatic test_err();
        logic [127:0] ser;
        int nb, nd, ne, fd;
        set_frame1();
        size_in = 6'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (err_b !== 1'b1) begin
            bad++;
            $display("FAIL err_g1: got %b expected 1", err_b);
        end
        capture(5, 1'b0, -1, ser, nb, nd, ne, fd);
        total++;
        if (ne !== 1) begin
            bad++;
            $display("FAIL err_count: got %0d expected 1", ne);
        end
        total++;
        if (nb !== 0 || nd !== 0) begin
            bad++;
            $display("FAIL err_busy_done: busy=%0d done=%0d expected 0 0", nb, nd);
        end
        total++;
        if (ser !== 128'(5'b11111)) begin
            bad++;
            $display("FAIL err_ser: got %b expected 11111", ser[4:0]);
        end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] ser;
        int nb, nd, ne, fd;
        set_frame1();
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(20, 1'b0, 8, ser, nb, nd, ne, fd);
        total++;
        if (ser !== 128'(20'h4F6FF)) begin
            bad++;
            $display("FAIL ignore_ser: got %h expected 4f6ff", ser[19:0]);
        end
        total++;
        if (nd !== 1 || nb !== 14) begin
            bad++;
            $display("FAIL ignore_done_busy: done=%0d busy=%0d expected 1 14", nd, nb);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ser;
        int nb, nd, ne, fd;
        port_in = 4'b1010;
        line_in = 2'b01;
        size_in = 6'd1;
        data_in = 63'h1;
        start = 1'b1;
        tick();
        capture(33, 1'b0, -1, ser, nb, nd, ne, fd);
        start = 1'b0;
        total++;
        if (ser !== 128'({3{11'b01010011111}})) begin
            bad++;
            $display("FAIL b2b_ser: got %h expected %h", ser[32:0], 33'({3{11'b01010011111}}));
        end
        total++;
        if (nb !== 30 || nd !== 3) begin
            bad++;
            $display("FAIL b2b_busy_done: busy=%0d done=%0d expected 30 3", nb, nd);
        end
        repeat (14) tick();
        total++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: busy_a=%b busy_b=%b expected 0 0", busy_a, busy_b);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] ser;
        int nb, nd, ne, fd;
        set_frame1();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        if ({ser_a, busy_a, done_a} !== 3'b100) begin
            bad++;
            $display("FAIL rstmid_out: ser/busy/done=%b expected 100", {ser_a, busy_a, done_a});
        end
        tick();
        total++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_hold: done=%b busy=%b expected 0 0", done_a, busy_a);
        end
        rst = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        capture(16, 1'b0, -1, ser, nb, nd, ne, fd);
        total++;
        if (ser !== 128'(16'h4F6F) || nb !== 14 || nd !== 1) begin
            bad++;
            $display("FAIL rstmid_frame: ser=%h busy=%0d done=%0d expected 4f6f 14 1", ser[15:0], nb, nd);
        end
    endtask

    task automatic test_max_size();
        logic [127:0] ser;
        logic [127:0] exp_ser;
        int nb, nd, ne, fd;
        repeat (4) tick();
        port_in = 4'b0110;
        line_in = 2'b10;
        size_in = 6'd63;
        data_in = 63'h5555_5555_5555_5555;
        exp_ser = 128'({1'b0, 6'b011010, 63'h5555_5555_5555_5555, 5'b11111});
        start = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        capture(75, 1'b1, -1, ser, nb, nd, ne, fd);
        total++;
        if (ser !== exp_ser) begin
            bad++;
            $display("FAIL max_ser: got %h expected %h", ser, exp_ser);
        end
        total++;
        if (nb !== 71) begin
            bad++;
            $display("FAIL max_busy: got %0d expected 71", nb);
        end
        total++;
        if (nd !== 1 || fd !== 70) begin
            bad++;
            $display("FAIL max_done: count=%0d at=%0d expected 1 at 70", nd, fd);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_err();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_max_size();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter GAP, default 2, number of idle-high cycles forced on serOut after each frame; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  frame request, sampled only while busy=0.
REQ-005 port_in  input  4  destination port, frame address bits 5..2.
REQ-006 line_in  input  2  destination line, frame address bits 1..0.
REQ-007 size_in  input  6  payload length in bits; legal 1..63.
REQ-008 data_in  input  63  payload; only bits [size_in-1:0] are sent.
REQ-009 serOut  output  1  serial line feeding the SReg6/Controller receive path; idle level 1.
REQ-010 busy  output  1  high while a frame or its gap is in progress.
REQ-011 done  output  1  one-cycle pulse at end of frame.
REQ-012 err  output  1  one-cycle pulse on a rejected request.

Function
REQ-013 FSM states SHALL be IDLE, START, ADDR, DATA and GAP; all outputs SHALL be registered.
REQ-014 In IDLE with start=1 and size_in!=0, the block SHALL latch port_in, line_in, size_in and data_in, then go to START; serOut SHALL be 0 in the following cycle (latency 1).
REQ-015 START SHALL last 1 cycle and then go to ADDR.
REQ-016 ADDR SHALL last 6 cycles and drive port[3], port[2], port[1], port[0], line[1], line[0] in that order, then go to DATA.
REQ-017 DATA SHALL last exactly size cycles and drive data[size-1] down to data[0] (MSB first), using a 6-bit down-counter; after that it SHALL go to GAP.
REQ-018 GAP SHALL drive serOut=1 for GAP cycles and then return to IDLE; done SHALL be 1 only in the first GAP cycle.
REQ-019 busy SHALL be 1 in every non-IDLE cycle; one accepted frame SHALL occupy exactly 7+size+GAP busy cycles.
REQ-020 start while busy=1 SHALL be ignored and not queued, and latched fields SHALL NOT change mid-frame.
REQ-021 In IDLE with start=1 and size_in=0, the block SHALL pulse err for 1 cycle, stay in IDLE, keep serOut=1 and keep busy=0.
REQ-022 start held high continuously SHALL produce back-to-back frames, each separated by exactly GAP idle cycles; the next START SHALL begin the cycle after the last GAP cycle plus 1 acceptance cycle.
REQ-023 size_in=63 SHALL transmit all 63 data bits without counter wrap.
REQ-024 serOut SHALL be 1 in every IDLE and GAP cycle.

Reset
REQ-025 rst=0 at a rising edge SHALL force state=IDLE, serOut=1, busy=0, done=0, err=0 and clear the counters and latched fields to 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately with no done pulse, and the block SHALL accept start in the first cycle after rst returns to 1.

Verification
REQ-027 The bench SHALL check: port_in=1001, line_in=11, size_in=5, data_in=...10110, 1-cycle start -> serOut = 0,1,0,0,1,1,1,1,0,1,1,0, then 1; done pulses in the cycle after the last bit; busy is high for 14 cycles (GAP=2).
REQ-028 The bench SHALL check: size_in=0 with start=1 -> err=1 for exactly 1 cycle, busy=0, serOut=1 throughout.
REQ-029 The bench SHALL check: second start pulse issued during the DATA phase of frame 1 -> ignored, only one done pulse, and serOut is identical to the single-frame case.
REQ-030 The bench SHALL check: start held high, size_in=1, data_in bit0=1, GAP=2 -> repeating period 0,p3,p2,p1,p0,l1,l0,1,1,1,x of 11 cycles, with x=1 being the acceptance cycle.
REQ-031 The bench SHALL check: rst=0 asserted during the 3rd ADDR cycle -> serOut=1, busy=0 next edge, no done; a new start after release produces a complete, correct frame.
REQ-032 The bench SHALL check: size_in=63, data_in=alternating 1010..., GAP=1 -> 63 alternating data bits after the address, busy high for 71 cycles, and done occurs once.
